// File: rtl/spi_pkg.sv
// Shared SPI definitions: default frame width, bus mode and the responder state type.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    // {CPOL, CPHA}; this bus runs mode 0 only.
    localparam logic [1:0] SPI_MODE = 2'b00;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_port_if.sv
// Pin-side and parallel-side signals of one SPI responder port.
interface spi_slave_port_if #(
    parameter int DATA_W = 8
);
    logic              sck;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              frame_abort;

    modport slave (
        input  sck, cs_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort
    );

    modport master (
        output sck, cs_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort
    );
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with registered rise/fall strobes.
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_last;
    logic              r_rise;
    logic              r_fall;

    // Synchronise the pin and compare the last stage with one extra flop to find edges.
    // NOTE: clocked state uses <= so every flop samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_last <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_last <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_last;
            r_fall <= ~r_sync[STAGES-1] & r_last;
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/spi_slave_port.sv
// Mode-0, MSB-first SPI responder: oversampled pins, one-byte transmit buffer, rx strobe.
module spi_slave_port
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_slave_port_if.slave bus
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall, w_mosi_sync;
    logic w_sck_level_unused, w_cs_level_unused, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_state_e        r_state, w_state_nxt;
    logic              w_start, w_end, w_abort, w_load, w_shift_tx, w_shift_rx, w_wr;
    logic [DATA_W-1:0] w_rx_next;

    logic [DATA_W-1:0] r_tx_shift, r_rx_shift, r_rx_data, r_buf;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_reload, r_buf_full, r_rx_valid, r_tx_underrun, r_frame_abort;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(clk), .rst_n(rst_n), .i_async(bus.sck),
        .o_sync(w_sck_level_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .i_async(bus.cs_n),
        .o_sync(w_cs_level_unused), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(clk), .rst_n(rst_n), .i_async(bus.mosi),
        .o_sync(w_mosi_sync), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    assign w_wr      = bus.tx_valid && !r_buf_full;
    assign w_rx_next = {r_rx_shift[DATA_W-2:0], w_mosi_sync};

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and per-cycle datapath controls; CS deassertion outranks any SCK strobe.
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        w_abort     = 1'b0;
        w_load      = 1'b0;
        w_shift_tx  = 1'b0;
        w_shift_rx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_ACTIVE;
                    w_start     = 1'b1;
                    w_load      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_end       = 1'b1;
                    w_abort     = (r_bit_cnt != '0);
                end else begin
                    w_shift_rx = w_sck_rise;
                    if (w_sck_fall) begin
                        w_load     = r_reload;
                        w_shift_tx = !r_reload;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Transmit buffer and shifter; a load in the same cycle as a write still sees the old (empty) buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf         <= '0;
            r_buf_full    <= 1'b0;
            r_tx_shift    <= '0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= w_load && !r_buf_full;
            if (w_load)          r_tx_shift <= r_buf_full ? r_buf : '0;
            else if (w_shift_tx) r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
            else if (w_end)      r_tx_shift <= '0;
            if (w_wr) begin
                r_buf      <= bus.tx_data;
                r_buf_full <= 1'b1;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end
        end
    end

    // Receive shifter, bit counter, byte-complete strobe and abort detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_bit_cnt     <= '0;
            r_reload      <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_frame_abort <= w_abort;
            if (w_end) begin
                r_rx_shift <= '0;
                r_bit_cnt  <= '0;
                r_reload   <= 1'b0;
            end else if (w_start) begin
                r_bit_cnt <= '0;
                r_reload  <= 1'b0;
            end else begin
                if (w_shift_rx) begin
                    r_rx_shift <= w_rx_next;
                    if (r_bit_cnt == LAST_BIT) begin
                        r_rx_data  <= w_rx_next;
                        r_rx_valid <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_reload   <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                if (w_load) r_reload <= 1'b0;
            end
        end
    end

    assign bus.miso        = (r_state == ST_ACTIVE) && r_tx_shift[DATA_W-1];
    assign bus.miso_oe     = (r_state == ST_ACTIVE);
    assign bus.tx_ready    = !r_buf_full;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.tx_underrun = r_tx_underrun;
    assign bus.frame_abort = r_frame_abort;

endmodule

// File: doc/spi_slave_port.md
# spi_slave_port

Synchronous SPI responder that terminates one chip-select line of the team's 4-slave SPI bus inside a clocked design. It oversamples the external SCK/CS_N/MOSI pins in the local `clk` domain, shifts received bits into a parallel byte, and serialises a preloaded transmit byte onto MISO. Parallel access is through a valid/ready transmit buffer and a one-cycle receive strobe. Mode 0 only (CPOL=0, CPHA=0), MSB first.

## Interface
- `DATA_W`, 8, frame width in bits
- `SYNC_STAGES`, 2, flip-flop stages on each asynchronous pin input (≥2)
- `clk` in 1: system clock; all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `sck` in 1: SPI clock from master (asynchronous)
- `cs_n` in 1: slave select, active low (asynchronous)
- `mosi` in 1: master-out data (asynchronous)
- `miso` out 1: slave-out data
- `miso_oe` out 1: MISO output enable; high only while selected
- `tx_data` in DATA_W: byte to transmit next
- `tx_valid` in 1: `tx_data` offered
- `tx_ready` out 1: transmit buffer empty
- `rx_data` out DATA_W: last complete received byte; held until next completion
- `rx_valid` out 1: one-cycle pulse, `rx_data` updated
- `tx_underrun` out 1: one-cycle pulse, byte started with empty buffer
- `frame_abort` out 1: one-cycle pulse, CS_N deasserted mid-byte

## Operation
- Pins pass through `SYNC_STAGES` flops; edge detect compares the last synced stage with one more flop. `sck_rise`, `sck_fall`, `cs_fall`, `cs_rise` are single-cycle internal strobes.
- States: IDLE (cs_n synced high), ACTIVE.
- IDLE→ACTIVE on `cs_fall`: load tx shifter from buffer (buffer empties) or with all-zeros plus `tx_underrun` pulse if empty; `bit_cnt`=0; `miso` = shifter MSB that cycle.
- ACTIVE, `sck_rise`: `rx_shift` ← {rx_shift[DATA_W-2:0], mosi_sync}; `bit_cnt`+1. On the DATA_W-th rise: `rx_data` ← completed byte next cycle, `rx_valid` pulse, `bit_cnt` wraps to 0, set `reload` flag.
- ACTIVE, `sck_fall`: if `reload`, load next byte from buffer (same empty/underrun rule), clear `reload`; else shift tx left by one. `miso` always = tx shifter MSB.
- ACTIVE→IDLE on `cs_rise`: if `bit_cnt`≠0, pulse `frame_abort`, discard partial rx (no `rx_valid`); clear `bit_cnt`, `reload`. Byte already in tx shifter is discarded; buffer is untouched.
- `sck` edges while IDLE are ignored.
- Transmit buffer: `tx_valid && tx_ready` writes buffer; `tx_ready` drops next cycle, rises the cycle after a load consumes it.
- Simultaneous write and load with empty buffer: load sees empty (zeros, `tx_underrun`); written byte stays for the following byte.
- `miso_oe` = ACTIVE; `miso` = 0 when IDLE.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, `frame_abort`=0; state IDLE, shifters and counter 0, buffer empty.
- Pin-to-strobe latency: SYNC_STAGES+1 clk cycles.
- SCK high and low time each ≥ SYNC_STAGES+2 clk cycles; CS_N fall to first SCK rise ≥ SYNC_STAGES+3 cycles so MISO MSB is stable.
- `rx_valid` asserts SYNC_STAGES+2 cycles after the final SCK rising pin edge.
- Reset mid-frame: all state to reset values immediately; after release, block stays IDLE until a fresh `cs_fall` (a CS_N already low at release does not start a frame).

## Structure
- Package `spi_pkg`: `DATA_W` default, mode-0 constant, IDLE/ACTIVE state enum; shared with the master.
- Sub-module `spi_pin_sync`: parameterised synchroniser plus rise/fall detector, instanced for `sck` and `cs_n`; `mosi` uses the synchroniser only.

## Test plan
- Preload 0x0F, master sends 0xF0 in one 8-bit frame → master receives 0x0F; `rx_data`=0xF0, one `rx_valid` pulse; `tx_ready` high again.
- Two back-to-back bytes in one CS: buffer 0xA5 then 0x3C written after first `tx_ready`; master sends 0x11, 0x22 → MISO 0xA5, 0x3C; two `rx_valid` with 0x11, 0x22.
- No preload, master sends 0xFF → `tx_underrun` pulse at CS fall, MISO all zeros, `rx_data`=0xFF.
- CS_N raised after 5 SCK rises → `frame_abort` pulse, no `rx_valid`, `rx_data` keeps prior value, next frame decodes correctly from bit 0.
- `rst_n` low during bit 4 → outputs at reset values; next full frame with 0x66 preload transfers 0x66 correctly.
- `tx_valid` with 0x5A in the same cycle as `cs_fall`, buffer empty → first byte 0x00 with `tx_underrun`, second byte 0x5A.
